// File: rtl/alu_issue_ctrl.sv
// Command FIFO and issue sequencer in front of the 2-bit alu.
// Issues one command, captures Y a cycle later, returns it via valid/ready.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_a,
  input  logic [1:0]       cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [1:0]       alu_A,
  output logic [1:0]       alu_B,
  output logic [1:0]       alu_sel,
  input  logic [3:0]       alu_Y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [1:0]       res_sel,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [AW:0] wr_ptr, rd_ptr;
  logic [5:0]  mem [DEPTH];
  logic [5:0]  head;
  logic        full, empty;
  logic        push, pop, hs;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign hs        = res_valid & res_ready;
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = RESP;
      RESP: begin
        if (hs) begin
          pop      = ~empty;
          state_nx = empty ? IDLE : ISSUE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // alu operands hold their last value between pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A   <= '0;
      alu_B   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      {alu_A, alu_B, alu_sel} <= head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
      op_count  <= '0;
    end else begin
      if (state == ISSUE) begin
        res_valid <= 1'b1;
        res_data  <= alu_Y;
        res_sel   <= alu_sel;
      end else if (state == RESP && hs) begin
        res_valid <= 1'b0;
      end
      if (hs) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an alu stub Y = {A, B}.
// A second instance with CNT_W=2 runs in lockstep for counter wrap.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_a, cmd_b, cmd_sel;
  logic       res_ready;

  logic       cmd_ready, res_valid, busy;
  logic [1:0] alu_A, alu_B, alu_sel, res_sel;
  logic [3:0] alu_Y, res_data;
  logic [7:0] op_count;

  logic       w_cmd_ready, w_res_valid, w_busy;
  logic [1:0] w_alu_A, w_alu_B, w_alu_sel, w_res_sel;
  logic [3:0] w_alu_Y, w_res_data;
  logic [1:0] w_op_count;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_d [8];
  logic [1:0] exp_s [8];

  always #5 clk = ~clk;

  assign alu_Y   = {alu_A, alu_B};
  assign w_alu_Y = {w_alu_A, w_alu_B};

  alu_issue_ctrl #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel),
    .alu_Y(alu_Y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sel(res_sel),
    .op_count(op_count), .busy(busy)
  );

  alu_issue_ctrl #(.DEPTH(4), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_A(w_alu_A), .alu_B(w_alu_B), .alu_sel(w_alu_sel),
    .alu_Y(w_alu_Y),
    .res_valid(w_res_valid), .res_ready(res_ready),
    .res_data(w_res_data), .res_sel(w_res_sel),
    .op_count(w_op_count), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] s);
    logic acc;
    int   t;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    t         = 0;
    do begin
      acc = cmd_ready;
      tick();
      t++;
    end while (!acc && t < 50);
    if (!acc) chk("push_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int first, input int n, input int base);
    for (int k = first; k < first + n; k++) begin
      int t = 0;
      while (!res_valid && t < 20) begin
        tick();
        t++;
      end
      if (!res_valid) begin
        chk("res_timeout", 0, 1);
        return;
      end
      chk("res_data", res_data, exp_d[k]);
      chk("res_sel", res_sel, exp_s[k]);
      chk("op_count", op_count, base + k - first);
      chk("wrap_cnt", w_op_count, (base + k - first) & 3);
      tick();
    end
  endtask

  initial begin
    int stale;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    res_ready = 1'b1;
    do_reset();

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_res_data", res_data, 0);

    // single op and its latency
    cmd_valid = 1'b1;
    cmd_a     = 2'b01;
    cmd_b     = 2'b10;
    cmd_sel   = 2'b00;
    tick();
    cmd_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_rv_early", res_valid, 0);
    tick();
    chk("t1_alu_A", alu_A, 2'b01);
    chk("t1_alu_B", alu_B, 2'b10);
    chk("t1_alu_sel", alu_sel, 2'b00);
    tick();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 4'b0110);
    chk("t1_res_sel", res_sel, 2'b00);
    tick();
    chk("t1_op_count", op_count, 1);
    chk("t1_rv_drop", res_valid, 0);
    chk("t1_busy_end", busy, 0);

    // fill with backpressure, then drain
    do_reset();
    res_ready = 1'b0;
    exp_d[0] = 4'b0110; exp_s[0] = 2'd0;
    exp_d[1] = 4'b1011; exp_s[1] = 2'd1;
    exp_d[2] = 4'b1100; exp_s[2] = 2'd2;
    exp_d[3] = 4'b0001; exp_s[3] = 2'd3;
    exp_d[4] = 4'b0101; exp_s[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      {cmd_a, cmd_b} = exp_d[i];
      cmd_sel = exp_s[i];
      chk("t2_rdy_before", cmd_ready, 1);
      tick();
    end
    chk("t2_full", cmd_ready, 0);
    cmd_a   = 2'b11;
    cmd_b   = 2'b11;
    cmd_sel = 2'b11;
    tick();
    cmd_valid = 1'b0;
    chk("t2_full_after6", cmd_ready, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_rv_hold", res_valid, 1);
      chk("t3_data_hold", res_data, 4'b0110);
      chk("t3_sel_hold", res_sel, 2'b00);
      chk("t3_cnt_hold", op_count, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t3_cnt_rel", op_count, 1);
    chk("t3_rv_gap", res_valid, 0);
    chk("t3_rdy_rel", cmd_ready, 1);
    tick();
    chk("t3_rv_next", res_valid, 1);
    collect(1, 4, 1);
    tick();
    tick();
    chk("t2_no_sixth", res_valid, 0);
    chk("t2_cnt_end", op_count, 5);
    chk("t2_busy_end", busy, 0);

    // streaming throughput and counter wrap
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = 4'b1100;
      exp_s[i] = 2'(i);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) push(2'b11, 2'b00, 2'(i));
      end
      collect(0, 8, 0);
    join
    tick();
    chk("t4_op_count", op_count, 8);
    chk("t5_wrap_end", w_op_count, 0);
    chk("t4_busy_end", busy, 0);

    // reset while a result is pending and two are queued
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(2'(i), 2'b01, 2'(i));
    chk("t6_pre_rv", res_valid, 1);
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rv", res_valid, 0);
    chk("t6_rdy", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", op_count, 0);
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) stale++;
    end
    chk("t6_no_stale", stale, 0);
    chk("t6_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
